// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the sequential square-root block.
//   state_t  : controller states IDLE / CALC / DONE
//   calc_qw  : root width for a given radical width
//   calc_rw  : remainder width for a given radical width
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned calc_qw(input int unsigned width);
    return (width + 1) / 2;
  endfunction

  function automatic int unsigned calc_rw(input int unsigned width);
    return calc_qw(width) + 1;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One combinational restoring square-root step.
//   r_in  : partial remainder (RW+1 bits, top two bits always zero on entry)
//   q_in  : partial root
//   bits  : next radical bit pair, MSB pair first
//   r_out : updated remainder
//   q_out : updated root (one more bit resolved)
module sqrt_step #(
  parameter int unsigned QW = 8,
  parameter int unsigned RW = QW + 1
) (
  input  logic [RW:0]   r_in,
  input  logic [QW-1:0] q_in,
  input  logic [1:0]    bits,
  output logic [RW:0]   r_out,
  output logic [QW-1:0] q_out
);

  logic [RW:0] shifted;
  logic [RW:0] trial;
  logic [1:0]  r_top_unused;

  // The remainder never exceeds 2q, so 4r+bits cannot spill out of RW+1 bits.
  assign r_top_unused = r_in[RW:RW-1];

  always_comb begin
    shifted = {r_in[RW-2:0], bits};
    trial   = {q_in, 2'b01};
    r_out   = shifted;
    q_out   = QW'({q_in, 1'b0});
    if (shifted >= trial) begin
      r_out = shifted - trial;
      q_out = QW'({q_in, 1'b1});
    end
  end

endmodule

// File: rtl/seq_sqrt.sv
// Sequential integer square root with valid/ready handshakes and a user tag.
//   clk, aclr_n     : rising-edge clock, asynchronous active-low clear
//   ena             : clock enable, freezes everything when low
//   flush           : synchronous abort back to IDLE
//   in_valid/ready  : radical + in_tag input handshake
//   out_valid/ready : q, remainder, out_tag output handshake
//   q               : floor(sqrt(radical)), remainder : radical - q*q
module seq_sqrt
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned STEPS_PER_CYCLE = 1,
  parameter int unsigned TAG_W           = 4,
  localparam int unsigned QW             = calc_qw(WIDTH),
  localparam int unsigned RW             = calc_rw(WIDTH)
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             ena,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] radical,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    q,
  output logic [RW-1:0]    remainder,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned S     = STEPS_PER_CYCLE;
  localparam int unsigned DW    = 2 * QW;
  localparam int unsigned NCYC  = QW / S;
  localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  state_t             state;
  logic [DW-1:0]      rad_sh;
  logic [QW-1:0]      q_acc;
  logic [RW:0]        r_acc;
  logic [CNT_W-1:0]   cnt;
  logic [TAG_W-1:0]   tag_hold;
  logic [QW-1:0]      q_next;
  logic [RW:0]        r_next;

  // Ready when idle, or when the held result is being taken this cycle.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

  // Chain of S restoring steps fed from the top bit pairs of the operand shifter.
  for (genvar i = 0; i < S; i++) begin : g_step
    logic [RW:0]   r_i;
    logic [RW:0]   r_o;
    logic [QW-1:0] q_i;
    logic [QW-1:0] q_o;
    if (i == 0) begin : g_first
      assign r_i = r_acc;
      assign q_i = q_acc;
    end else begin : g_next
      assign r_i = g_step[i-1].r_o;
      assign q_i = g_step[i-1].q_o;
    end
    sqrt_step #(
      .QW(QW),
      .RW(RW)
    ) u_step (
      .r_in (r_i),
      .q_in (q_i),
      .bits (rad_sh[DW-1-2*i -: 2]),
      .r_out(r_o),
      .q_out(q_o)
    );
  end

  assign q_next = g_step[S-1].q_o;
  assign r_next = g_step[S-1].r_o;

  // Controller, operand/accumulator registers and output registers.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state     <= IDLE;
      rad_sh    <= '0;
      q_acc     <= '0;
      r_acc     <= '0;
      cnt       <= '0;
      tag_hold  <= '0;
      q         <= '0;
      remainder <= '0;
      out_tag   <= '0;
      out_valid <= 1'b0;
    end else if (ena) begin
      if (flush) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              rad_sh   <= DW'(radical);
              tag_hold <= in_tag;
              q_acc    <= '0;
              r_acc    <= '0;
              cnt      <= '0;
              state    <= CALC;
            end
          end
          CALC: begin
            rad_sh <= rad_sh << (2 * S);
            q_acc  <= q_next;
            r_acc  <= r_next;
            if (cnt == CNT_W'(NCYC - 1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              q         <= q_next;
              remainder <= r_next[RW-1:0];
              out_tag   <= tag_hold;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DONE: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (in_valid) begin
                rad_sh   <= DW'(radical);
                tag_hold <= in_tag;
                q_acc    <= '0;
                r_acc    <= '0;
                cnt      <= '0;
                state    <= CALC;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_sqrt.sv
// Scoreboard bench for seq_sqrt: directed scenarios on a 16-bit instance,
// a 32-bit two-steps-per-cycle instance, and random traffic on widths 2..20.
module tb_seq_sqrt;

  localparam int unsigned W   = 16;
  localparam int unsigned TW  = 4;
  localparam int unsigned QWM = 8;
  localparam int unsigned RWM = 9;

  typedef struct {
    longint unsigned q;
    longint unsigned r;
    longint unsigned tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           aclr_n, ena, flush, in_valid, out_ready;
  logic [W-1:0]   radical;
  logic [TW-1:0]  in_tag, out_tag;
  logic           in_ready, out_valid;
  logic [QWM-1:0] q;
  logic [RWM-1:0] remainder;

  logic           w_iv, w_ir, w_ov, w_ordy;
  logic [31:0]    w_rd;
  logic [TW-1:0]  w_tg, w_otag;
  logic [15:0]    w_q;
  logic [16:0]    w_rem;

  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  bit   go       = 1'b0;
  bit   stream_on;
  exp_t sb[$];

  longint unsigned dx[3] = '{99, 0, 65535};
  longint unsigned dq[3] = '{9, 0, 255};
  longint unsigned dr[3] = '{18, 0, 510};

  // Largest q with q*q <= x, found by bitwise guess-and-check.
  function automatic longint unsigned ref_sqrt(input longint unsigned x);
    longint unsigned r = 0;
    for (int b = 16; b >= 0; b--) begin
      longint unsigned c = r | (64'd1 << b);
      if (c * c <= x) r = c;
    end
    return r;
  endfunction

  function automatic exp_t mk_exp(input longint unsigned x, input longint unsigned t);
    exp_t e;
    e.q   = ref_sqrt(x);
    e.r   = x - e.q * e.q;
    e.tag = t;
    return e;
  endfunction

  function automatic void check(input string name, input longint unsigned act,
                                input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  seq_sqrt #(.WIDTH(W), .STEPS_PER_CYCLE(1), .TAG_W(TW)) u_dut (
    .clk(clk), .aclr_n(aclr_n), .ena(ena), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .radical(radical), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .remainder(remainder),
    .out_tag(out_tag)
  );

  seq_sqrt #(.WIDTH(32), .STEPS_PER_CYCLE(2), .TAG_W(TW)) u_w32 (
    .clk(clk), .aclr_n(aclr_n), .ena(1'b1), .flush(1'b0),
    .in_valid(w_iv), .in_ready(w_ir), .radical(w_rd), .in_tag(w_tg),
    .out_valid(w_ov), .out_ready(w_ordy), .q(w_q), .remainder(w_rem),
    .out_tag(w_otag)
  );

  // Main monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (aclr_n && ena && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL main_unexpected: got result q=%0d with nothing pending", q);
      end else begin
        e = sb.pop_front();
        check("main_q", 64'(q), e.q);
        check("main_rem", 64'(remainder), e.r);
        check("main_tag", 64'(out_tag), e.tag);
      end
    end
  end

  // Random traffic on every width 2..20, one step per cycle and all steps in one cycle.
  for (genvar gw = 2; gw <= 20; gw++) begin : g_w
    for (genvar gs = 0; gs < 2; gs++) begin : g_s
      localparam int unsigned GQ = (gw + 1) / 2;
      localparam int unsigned GS = (gs == 0) ? 1 : GQ;
      logic          g_iv, g_ir, g_ov, g_ordy;
      logic [gw-1:0] g_rd;
      logic [TW-1:0] g_tg, g_otag;
      logic [GQ-1:0] g_q;
      logic [GQ:0]   g_rem;
      exp_t          g_sb[$];

      seq_sqrt #(.WIDTH(gw), .STEPS_PER_CYCLE(GS), .TAG_W(TW)) u_g (
        .clk(clk), .aclr_n(aclr_n), .ena(1'b1), .flush(1'b0),
        .in_valid(g_iv), .in_ready(g_ir), .radical(g_rd), .in_tag(g_tg),
        .out_valid(g_ov), .out_ready(g_ordy), .q(g_q), .remainder(g_rem),
        .out_tag(g_otag)
      );

      initial begin : drive
        logic ok;
        g_iv = 1'b0;
        g_rd = '0;
        g_tg = '0;
        wait (go);
        @(posedge clk); #1;
        for (int k = 0; k < 24; k++) begin
          if (k == 0) g_rd = '0;
          else if (k == 1) g_rd = '1;
          else g_rd = gw'($urandom);
          g_tg = TW'(k);
          g_iv = 1'b1;
          ok   = 1'b0;
          for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = g_ir;
            @(posedge clk); #1;
          end
          g_iv = 1'b0;
          if (ok) g_sb.push_back(mk_exp(64'(g_rd), 64'(g_tg)));
          else begin
            checks++;
            failures++;
            $display("FAIL w%0d_s%0d_accept: radical %0d never accepted", gw, GS, g_rd);
          end
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        for (int t = 0; t < 500 && g_sb.size() != 0; t++) begin @(posedge clk); #1; end
        check($sformatf("w%0d_s%0d_drain", gw, GS), 64'(g_sb.size()), 0);
        done_cnt++;
      end

      initial begin : ready_gen
        g_ordy = 1'b0;
        wait (go);
        forever begin
          @(posedge clk); #1;
          g_ordy = 1'($urandom_range(0, 1));
        end
      end

      always @(negedge clk) begin
        exp_t e;
        if (aclr_n && g_ov && g_ordy) begin
          if (g_sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL w%0d_s%0d_unexpected: got q=%0d with nothing pending", gw, GS, g_q);
          end else begin
            e = g_sb.pop_front();
            check($sformatf("w%0d_s%0d_q", gw, GS), 64'(g_q), e.q);
            check($sformatf("w%0d_s%0d_rem", gw, GS), 64'(g_rem), e.r);
            check($sformatf("w%0d_s%0d_tag", gw, GS), 64'(g_otag), e.tag);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [TW-1:0] t);
    logic ok;
    radical  = x;
    in_tag   = t;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready && ena && !flush;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (ok) sb.push_back(mk_exp(64'(x), 64'(t)));
    else begin
      checks++;
      failures++;
      $display("FAIL main_accept: radical %0d never accepted", x);
    end
  endtask

  task automatic wait_valid(output int n, input int maxc);
    n = 0;
    while (!out_valid && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [W-1:0] x;
    aclr_n = 1'b0; ena = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    radical = '0; in_tag = '0;
    w_iv = 1'b0; w_rd = '0; w_tg = '0; w_ordy = 1'b0;
    #12;
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_q", 64'(q), 0);
    check("reset_rem", 64'(remainder), 0);
    check("reset_tag", 64'(out_tag), 0);
    aclr_n = 1'b1;
    tick();
    check("release_in_ready", 64'(in_ready), 1);

    // Directed values with known roots and latency.
    for (int i = 0; i < 3; i++) begin
      send(W'(dx[i]), TW'(i + 1));
      wait_valid(n, 30);
      check($sformatf("lat_%0d", dx[i]), 64'(n), 8);
      check($sformatf("q_%0d", dx[i]), 64'(q), dq[i]);
      check($sformatf("rem_%0d", dx[i]), 64'(remainder), dr[i]);
      take();
    end

    // Result held under backpressure, then back-to-back accept.
    send(16'd200, 4'd5);
    wait_valid(n, 30);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 64'(out_valid), 1);
      check("hold_q", 64'(q), 14);
      check("hold_rem", 64'(remainder), 4);
      check("hold_tag", 64'(out_tag), 5);
    end
    out_ready = 1'b1;
    send(16'd1000, 4'd6);
    out_ready = 1'b0;
    wait_valid(n, 30);
    check("b2b_latency", 64'(n), 8);
    take();

    // Flush in the third CALC cycle, with an offered input that must be ignored.
    send(16'd50000, 4'd7);
    tick();
    tick();
    flush = 1'b1; in_valid = 1'b1; radical = 16'd5;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", 64'(out_valid), 0);
    check("flush_idle_ready", 64'(in_ready), 1);
    repeat (12) tick();
    check("flush_no_result", 64'(out_valid), 0);
    send(16'd144, 4'd8);
    wait_valid(n, 30);
    check("post_flush_q", 64'(q), 12);
    check("post_flush_rem", 64'(remainder), 0);
    take();

    // Asynchronous clear in the middle of CALC.
    send(16'd777, 4'd9);
    repeat (3) tick();
    aclr_n = 1'b0;
    #1;
    check("aclr_out_valid", 64'(out_valid), 0);
    check("aclr_q", 64'(q), 0);
    check("aclr_rem", 64'(remainder), 0);
    check("aclr_tag", 64'(out_tag), 0);
    sb.delete();
    #2;
    aclr_n = 1'b1;
    tick();
    check("aclr_in_ready", 64'(in_ready), 1);
    repeat (12) tick();
    check("aclr_no_result", 64'(out_valid), 0);

    // Enable low every other cycle doubles latency in clocks.
    x = W'($urandom);
    send(x, 4'd10);
    n = 0;
    while (!out_valid && n < 40) begin
      ena = n[0];
      tick();
      n++;
    end
    ena = 1'b1;
    check("ena_toggle_latency", 64'(n), 16);
    take();

    // 32-bit, two steps per cycle.
    w_rd = 32'd1000000; w_tg = 4'd3; w_iv = 1'b1;
    @(negedge clk);
    check("w32_in_ready", 64'(w_ir), 1);
    tick();
    w_iv = 1'b0;
    n = 0;
    while (!w_ov && n < 30) begin
      tick();
      n++;
    end
    check("w32_latency", 64'(n), 8);
    check("w32_q", 64'(w_q), 1000);
    check("w32_rem", 64'(w_rem), 0);
    check("w32_tag", 64'(w_otag), 3);
    w_ordy = 1'b1;
    tick();
    w_ordy = 1'b0;

    // Random stream with random enable and output backpressure.
    stream_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          send(W'($urandom), TW'($urandom));
          repeat ($urandom_range(0, 2)) tick();
        end
        stream_on = 1'b0;
      end
      begin
        while (stream_on) begin
          out_ready = 1'($urandom_range(0, 1));
          ena       = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    ena = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && sb.size() != 0; t++) tick();
    check("stream_drain", 64'(sb.size()), 0);
    out_ready = 1'b0;

    go = 1'b1;
    for (int t = 0; t < 20000 && done_cnt < 38; t++) tick();
    check("sweep_done", 64'(done_cnt), 38);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
